// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and defaults for the mux channel scanner
// Purpose: FSM state encoding, default geometry of the scanned 8:1 mux, and a
//          helper that sizes the settle counter.
// Ports:   none (package)
package mux_scan_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NCH_DEF    = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_e;

  // Counter holds 0..SETTLE-1; keep at least one bit so SETTLE=1 still builds.
  function automatic int cnt_width(input int settle);
    int w;
    w = $clog2(settle);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter timing the mux settle window
// Purpose: loaded with SETTLE-1 on every select change, decremented while the
//          scanner waits, flags zero when the mux output may be sampled.
// Ports:   clk, rst (sync, active high), load (reload SETTLE-1), dec (count
//          down, saturating at 0), zero (counter is 0).
module settle_counter
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = cnt_width(SETTLE)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// rtl/mux_channel_scanner.sv - steps an 8:1 mux select and streams tagged samples
// Purpose: walks sel through channels 0..NCH-1, waits SETTLE cycles per channel,
//          captures mux_out and offers (smp_ch, smp_data) on a valid/ready port.
//          Runs one scan, or repeats scans until stop is seen.
// Ports:   clk, rst (sync, active high)
//          start, continuous, stop         - control
//          mux_out -> / sel <-             - mux connection
//          smp_data, smp_ch, smp_valid, smp_ready - sample stream
//          busy, done, scan_cnt            - status
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic [WIDTH-1:0] mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] smp_data,
  output logic [SEL_W-1:0] smp_ch,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic [7:0]       scan_cnt
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

  scan_state_e      state_q,     state_d;
  logic [SEL_W-1:0] sel_q,       sel_d;
  logic [WIDTH-1:0] smp_data_q,  smp_data_d;
  logic [SEL_W-1:0] smp_ch_q,    smp_ch_d;
  logic             smp_valid_q, smp_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [7:0]       scan_cnt_q,  scan_cnt_d;
  logic             cont_q,      cont_d;
  logic             stop_q,      stop_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    smp_data_d  = smp_data_q;
    smp_ch_d    = smp_ch_q;
    smp_valid_d = smp_valid_q;
    scan_cnt_d  = scan_cnt_q;
    cont_d      = cont_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    // stop only sticks while a scan is running; in IDLE it is ignored.
    stop_d      = stop_q | (busy_q & stop);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          sel_d    = '0;
          cont_d   = continuous;
          cnt_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_CAPTURE: begin
        smp_data_d  = mux_out;
        smp_ch_d    = sel_q;
        smp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        // sel only moves on the handshake, so the mux stays put while the
        // consumer back-pressures.
        if (smp_valid_q && smp_ready) begin
          smp_valid_d = 1'b0;
          if (sel_q != LAST_CH) begin
            sel_d    = sel_q + SEL_W'(1);
            cnt_load = 1'b1;
            state_d  = ST_SETTLE;
          end else begin
            sel_d      = '0;
            scan_cnt_d = scan_cnt_q + 8'd1;
            if (cont_q && !stop_q) begin
              cnt_load = 1'b1;
              state_d  = ST_SETTLE;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              cont_d  = 1'b0;
              stop_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      smp_data_q  <= '0;
      smp_ch_q    <= '0;
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_cnt_q  <= 8'd0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      smp_data_q  <= smp_data_d;
      smp_ch_q    <= smp_ch_d;
      smp_valid_q <= smp_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scan_cnt_q  <= scan_cnt_d;
      cont_q      <= cont_d;
      stop_q      <= stop_d;
    end
  end

  assign sel       = sel_q;
  assign smp_data  = smp_data_q;
  assign smp_ch    = smp_ch_q;
  assign smp_valid = smp_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign scan_cnt  = scan_cnt_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb/tb_mux_channel_scanner.sv - scoreboard bench for mux_channel_scanner
module tb_mux_channel_scanner;

  localparam int WIDTH    = 8;
  localparam int NCH      = 8;
  localparam int SEL_W    = 3;
  localparam int SETTLE   = 2;
  localparam int PERIOD   = SETTLE + 2;
  localparam int SCAN_CYC = NCH * PERIOD;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             continuous;
  logic             stop;
  logic [WIDTH-1:0] mux_out;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] smp_data;
  logic [SEL_W-1:0] smp_ch;
  logic             smp_valid;
  logic             smp_ready;
  logic             busy;
  logic             done;
  logic [7:0]       scan_cnt;

  // Multiplexer_8_1 stand-in: in0..in7 = 128,64,32,16,8,4,2,1
  int mux_val [0:7] = '{128, 64, 32, 16, 8, 4, 2, 1};
  assign mux_out = WIDTH'(mux_val[sel]);

  mux_channel_scanner #(
    .WIDTH (WIDTH), .NCH (NCH), .SEL_W (SEL_W), .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .mux_out    (mux_out),
    .sel        (sel),
    .smp_data   (smp_data),
    .smp_ch     (smp_ch),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .busy       (busy),
    .done       (done),
    .scan_cnt   (scan_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int exp_ch_q[$];
  int exp_data_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
      if (exp_ch_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_sample: got ch=%0d data=%0d required none", smp_ch, smp_data);
      end else begin
        chk("sample_ch", int'(smp_ch), exp_ch_q.pop_front());
        chk("sample_data", int'(smp_data), exp_data_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan();
    for (int c = 0; c < NCH; c++) begin
      exp_ch_q.push_back(c);
      exp_data_q.push_back(mux_val[c]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ch_q.delete();
    exp_data_q.delete();
  endtask

  task automatic pulse_start(output int scyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    scyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string name, output int dcyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (done !== 1'b1) fail_now(name);
    dcyc = cyc;
  endtask

  int scyc, dcyc, d0, k;

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; smp_ready = 1'b0;
    do_reset();

    // reset state
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(smp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_scan_cnt", int'(scan_cnt), 0);
    chk("rst_smp_data", int'(smp_data), 0);

    // 1: single scan, ready always high
    smp_ready = 1'b1;
    push_scan();
    d0 = done_cnt;
    pulse_start(scyc);
    chk("t1_busy_after_start", int'(busy), 1);
    tick(); chk("t1_valid_n1", int'(smp_valid), 0);
    tick(); chk("t1_valid_n2", int'(smp_valid), 0);
    tick(); chk("t1_valid_n3", int'(smp_valid), 1);
    wait_done(SCAN_CYC + 20, "t1_done", dcyc);
    chk("t1_done_time", dcyc - scyc, SCAN_CYC);
    chk("t1_scan_cnt", int'(scan_cnt), 1);
    chk("t1_busy_at_done", int'(busy), 0);
    repeat (5) tick();
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_queue_empty", exp_ch_q.size(), 0);

    // 2: backpressure on the first sample
    smp_ready = 1'b0;
    push_scan();
    pulse_start(scyc);
    k = 0;
    while (smp_valid !== 1'b1 && k < 20) begin tick(); k++; end
    if (smp_valid !== 1'b1) fail_now("t2_first_valid");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_hold_valid", int'(smp_valid), 1);
      chk("t2_hold_data", int'(smp_data), 128);
      chk("t2_hold_sel", int'(sel), 0);
    end
    smp_ready = 1'b1;
    wait_done(SCAN_CYC + 20, "t2_done", dcyc);
    chk("t2_scan_cnt", int'(scan_cnt), 2);
    tick();
    chk("t2_queue_empty", exp_ch_q.size(), 0);

    // 5: stop while idle, start while busy -> both ignored
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t5_idle_after_stop", int'(busy), 0);
    push_scan();
    d0 = done_cnt;
    pulse_start(scyc);
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(SCAN_CYC + 20, "t5_done", dcyc);
    chk("t5_done_time", dcyc - scyc, SCAN_CYC);
    repeat (5) tick();
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_scan_cnt", int'(scan_cnt), 3);
    chk("t5_busy", int'(busy), 0);
    chk("t5_queue_empty", exp_ch_q.size(), 0);

    // 3: continuous; stop with start is not latched, stop in scan 2 is
    push_scan();
    push_scan();
    d0 = done_cnt;
    continuous = 1'b1;
    stop = 1'b1;
    pulse_start(scyc);
    stop = 1'b0;
    continuous = 1'b0;
    repeat (SCAN_CYC + 8) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done(SCAN_CYC + 20, "t3_done", dcyc);
    chk("t3_done_time", dcyc - scyc, 2 * SCAN_CYC);
    chk("t3_scan_cnt", int'(scan_cnt), 5);
    repeat (5) tick();
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_queue_empty", exp_ch_q.size(), 0);

    // 4: reset while holding ch3
    push_scan();
    pulse_start(scyc);
    k = 0;
    while (!(smp_valid === 1'b1 && smp_ch == 3'd3) && k < 100) begin tick(); k++; end
    smp_ready = 1'b0;
    if (k >= 100) fail_now("t4_reach_ch3");
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_ch_q.delete();
    exp_data_q.delete();
    chk("t4_sel", int'(sel), 0);
    chk("t4_valid", int'(smp_valid), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_scan_cnt", int'(scan_cnt), 0);
    smp_ready = 1'b1;
    push_scan();
    pulse_start(scyc);
    wait_done(SCAN_CYC + 20, "t4_done", dcyc);
    chk("t4_done_time", dcyc - scyc, SCAN_CYC);
    chk("t4_scan_cnt_after", int'(scan_cnt), 1);
    tick();
    chk("t4_queue_empty", exp_ch_q.size(), 0);

    // 6: 256 continuous scans -> scan_cnt wraps to 0
    do_reset();
    for (int s = 0; s < 256; s++) push_scan();
    smp_ready = 1'b1;
    continuous = 1'b1;
    pulse_start(scyc);
    continuous = 1'b0;
    k = 0;
    while (scan_cnt != 8'd255 && k < 256 * SCAN_CYC + 200) begin tick(); k++; end
    if (scan_cnt != 8'd255) fail_now("t6_reach_255");
    chk("t6_busy_at_255", int'(busy), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done(SCAN_CYC + 20, "t6_done", dcyc);
    chk("t6_done_time", dcyc - scyc, 256 * SCAN_CYC);
    chk("t6_scan_cnt_wrap", int'(scan_cnt), 0);
    tick();
    chk("t6_queue_empty", exp_ch_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
